// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Multicycle instruction fetch front end. Keeps one request outstanding
// towards instruction memory and presents the raw decode fields of each
// fetched word to control_unit over a valid/ready handshake. A redirect
// loads a new PC and flushes whatever fetch is in progress.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_valid/addr request towards memory (addr is the PC register)
//   imem_req_ready      memory accepts the request this cycle
//   imem_rsp_valid/data instruction word from memory (never back-pressured)
//   redirect_valid/pc   branch/jump target; low two bits are ignored
//   dec_valid/ready     handshake towards decode
//   opcode, func3,      raw fields of the presented instruction
//   func7, imm_data     (imm_data = instr[31:12], extended downstream)
//   dec_pc              PC of the presented instruction
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [6:0]        opcode,
   output logic [2:0]        func3,
   output logic [6:0]        func7,
   output logic [19:0]       imm_data,
   output logic [ADDR_W-1:0] dec_pc
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] redirect_aligned;
   logic [ADDR_W-1:0] pc_inc;
   logic              req_accept;

   // Instructions are word aligned; the two low target bits are dropped.
   assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign pc_inc           = pc_reg + ADDR_W'(PC_STEP);
   assign imem_req_addr    = pc_reg;

   // imem_req_valid is a register that comes out of reset low, so the first
   // REQ cycle after reset only raises it. A handshake only counts when the
   // request was actually visible to memory.
   assign req_accept = imem_req_valid && imem_req_ready;

   // Bits [11:7] (rd) are not part of the decode interface.
   logic unused_bits;
   assign unused_bits = ^{redirect_pc[1:0], imem_rsp_data[11:7]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_REQ;
         pc_reg         <= RESET_PC;
         imem_req_valid <= 1'b0;
         dec_valid      <= 1'b0;
         dec_pc         <= '0;
         opcode         <= '0;
         func3          <= '0;
         func7          <= '0;
         imm_data       <= '0;
      end else if (redirect_valid) begin
         // Redirect wins over every other event this cycle. Whether the
         // old request is still owed a response decides REQ vs DRAIN.
         pc_reg    <= redirect_aligned;
         dec_valid <= 1'b0;
         case (state_reg)
            S_REQ: begin
               if (req_accept) begin
                  state_reg      <= S_DRAIN;
                  imem_req_valid <= 1'b0;
               end else begin
                  state_reg      <= S_REQ;
                  imem_req_valid <= 1'b1;
               end
            end
            S_WAIT, S_DRAIN: begin
               if (imem_rsp_valid) begin
                  state_reg      <= S_REQ;
                  imem_req_valid <= 1'b1;
               end else begin
                  state_reg      <= S_DRAIN;
                  imem_req_valid <= 1'b0;
               end
            end
            default: begin
               // HOLD: held instruction is discarded even if consumed now.
               state_reg      <= S_REQ;
               imem_req_valid <= 1'b1;
            end
         endcase
      end else begin
         case (state_reg)
            S_REQ: begin
               if (req_accept) begin
                  state_reg      <= S_WAIT;
                  imem_req_valid <= 1'b0;
               end else begin
                  imem_req_valid <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  opcode    <= imem_rsp_data[6:0];
                  func3     <= imem_rsp_data[14:12];
                  func7     <= imem_rsp_data[31:25];
                  imm_data  <= imem_rsp_data[31:12];
                  dec_pc    <= pc_reg;
                  pc_reg    <= pc_inc;
                  state_reg <= S_HOLD;
                  dec_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (dec_ready) begin
                  state_reg      <= S_REQ;
                  dec_valid      <= 1'b0;
                  imem_req_valid <= 1'b1;
               end
            end
            default: begin
               // DRAIN: the response belongs to a flushed fetch; drop it.
               if (imem_rsp_valid) begin
                  state_reg      <= S_REQ;
                  imem_req_valid <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the decoder interface: fetches 32-bit instruction words from instruction memory and presents them to control_unit.
- Outputs are the raw decode fields opcode, func3, func7 and imm_data.
- Multicycle fetch: one outstanding memory request at a time, with a valid/ready handshake towards decode and a PC redirect input for branches and jumps.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, PC increment per fetched instruction, in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch address; always equal to the PC register.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  instruction word valid; always accepted, there is no back-pressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  load a new PC and flush the fetch in progress.
- redirect_pc  in  ADDR_W  target PC.
- dec_valid  out  1  decode fields hold a valid instruction.
- dec_ready  in  1  decoder consumes the instruction this cycle.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- imm_data  out  20  instr[31:12]; control_unit performs the extension.
- dec_pc  out  ADDR_W  PC of the presented instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=REQ.
  - imem_req_valid=0, dec_valid=0, dec_pc=0.
  - opcode/func3/func7/imm_data = 0. This is the NOP pattern, so control_unit write_en=0.
- Reset mid-operation: all state is dropped immediately, including any held instruction and any in-flight request.
- Outputs are registered: imem_req_valid and dec_valid are decoded from state only, with no combinational path from any input.
- States: REQ, WAIT, HOLD, DRAIN.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc; the address is held stable until accepted.
  - On imem_req_ready, go to WAIT.
- WAIT:
  - On imem_rsp_valid: capture the fields from imem_rsp_data, set dec_pc=pc, pc<=pc+PC_STEP, go to HOLD. dec_valid=1 from the next cycle.
  - A response arriving in any other state is ignored, except in DRAIN.
- HOLD:
  - dec_valid=1; fields and dec_pc stay stable while dec_ready=0.
  - On dec_ready, go to REQ; dec_valid=0 next cycle.
- Minimum fetch latency is 3 cycles: REQ accept, response, HOLD.
- PC arithmetic: modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 wraps to 0.
- redirect_pc[1:0] is forced to 2'b00.
- Redirect has priority over every other event in the same cycle. pc<=redirect_pc (masked), and dec_valid goes to 0 next cycle. Next state by current state:
  - REQ with imem_req_ready=0: go to REQ; the new address appears next cycle.
  - REQ with imem_req_ready=1: the memory has accepted the old request, so go to DRAIN.
  - WAIT with imem_rsp_valid=1: drop the response and go to REQ.
  - WAIT with imem_rsp_valid=0: go to DRAIN.
  - HOLD: discard the held instruction even if dec_ready=1, and go to REQ.
  - DRAIN: update pc; if imem_rsp_valid, go to REQ, else stay in DRAIN.
- DRAIN without a redirect: wait for imem_rsp_valid, discard the data, then go to REQ.
- Decode fields keep their last captured value when dec_valid=0. In DRAIN they are never updated.
- Only one request is ever outstanding: imem_req_valid=0 in WAIT, HOLD and DRAIN.

Test Plan:
- Reset, then memory ready=1 with one-cycle response 32'h00A00093 at addr 0:
  - imem_req_addr=0.
  - dec_valid=1 with opcode=7'h13, func3=0, func7=0, imm_data=20'h00A00, dec_pc=0.
  - Next request addr=4.
- Back-pressure: dec_ready=0 for 5 cycles in HOLD:
  - fields and dec_valid stay stable, imem_req_valid=0.
  - On dec_ready=1, the next cycle shows REQ with addr=4.
- imem_req_ready low for 3 cycles: imem_req_addr is held at 8 throughout; accepted on the 4th cycle.
- Redirect in WAIT to 32'h0000_0103:
  - The late response 32'hFFFFFFFF is discarded and dec_valid stays 0.
  - The next request addr=32'h100.
  - The following instruction is presented with dec_pc=32'h100.
- Redirect same cycle as dec_ready in HOLD to 32'h40: the held instruction is not re-presented and the next request addr=32'h40.
- RESET_PC=32'hFFFF_FFFC, two fetches: dec_pc=32'hFFFF_FFFC, then the second request addr=0.
- Assert rst_n=0 while in HOLD: dec_valid and imem_req_valid drop immediately, fields read 0, and the first request after release is at RESET_PC.
